// File: rtl/uart_tx_report.sv
// UART 8N1 transmitter that streams a snapshotted packed-BCD word as ASCII digits, MSD first.
// Define TX_CRLF_EN to append a CR/LF trailer to every report.
module uart_tx_report #(
    parameter int BIT_TICKS = 16,
    parameter int N_DIG     = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [4*N_DIG-1:0] bcd,
    output logic               uart_tx,
    output logic               busy,
    output logic               done,
    output logic               err
);

`ifdef TX_CRLF_EN
    localparam int N_CHARS = N_DIG + 2;
`else
    localparam int N_CHARS = N_DIG;
`endif
    localparam int TW = $clog2(BIT_TICKS);
    localparam int DW = $clog2(N_CHARS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
    localparam logic [DW-1:0] DIG_LAST  = DW'(N_CHARS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]         state, state_n;
    logic [TW-1:0]      tick_cnt, tick_n;
    logic [2:0]         bit_cnt, bit_n;
    logic [DW-1:0]      dig_idx, dig_n;
    logic [4*N_DIG-1:0] snap, snap_n;
    logic               busy_n, done_n, err_n, tx_n;
    logic               tick_wrap;
    logic [7:0]         char_n;

    // Character for report slot idx: BCD digits first, then the optional CR/LF trailer.
    function automatic logic [7:0] char_at(input logic [4*N_DIG-1:0] s, input logic [DW-1:0] idx);
        logic [4*N_DIG-1:0] sh;
        logic [3:0]         d;
        sh = s << (4 * int'(idx));
        d  = sh[4*N_DIG-1 -: 4];
        if (int'(idx) < N_DIG)
            char_at = (d > 4'd9) ? 8'h3F : 8'h30 + {4'h0, d};
`ifdef TX_CRLF_EN
        else if (int'(idx) == N_DIG)
            char_at = 8'h0D;
        else
            char_at = 8'h0A;
`else
        else
            char_at = 8'h0A;
`endif
    endfunction

    always_comb begin
        state_n   = state;
        tick_n    = tick_cnt;
        bit_n     = bit_cnt;
        dig_n     = dig_idx;
        snap_n    = snap;
        busy_n    = busy;
        done_n    = 1'b0;
        err_n     = err;
        tick_wrap = (tick_cnt == TICK_LAST);

        case (state)
            // FINISH is the done cycle; it accepts a new start just like IDLE.
            S_IDLE, S_FINISH: begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
                if (start) begin
                    snap_n  = bcd;
                    err_n   = 1'b0;
                    busy_n  = 1'b1;
                    state_n = S_START;
                    tick_n  = '0;
                    bit_n   = '0;
                    dig_n   = '0;
                end
            end
            S_START: begin
                if (tick_wrap) begin
                    tick_n  = '0;
                    bit_n   = '0;
                    state_n = S_DATA;
                end else begin
                    tick_n = tick_cnt + TW'(1);
                end
            end
            S_DATA: begin
                if (tick_wrap) begin
                    tick_n = '0;
                    if (bit_cnt == 3'd7)
                        state_n = S_STOP;
                    else
                        bit_n = bit_cnt + 3'd1;
                end else begin
                    tick_n = tick_cnt + TW'(1);
                end
            end
            S_STOP: begin
                if (tick_wrap) begin
                    tick_n = '0;
                    if (dig_idx == DIG_LAST) begin
                        state_n = S_FINISH;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        dig_n   = dig_idx + DW'(1);
                        state_n = S_START;
                    end
                end else begin
                    tick_n = tick_cnt + TW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        // err rises as the start bit of an invalid digit goes out.
        char_n = char_at(snap_n, dig_n);
        if (state_n == S_START && state != S_START && char_n == 8'h3F)
            err_n = 1'b1;

        tx_n = 1'b1;
        if (state_n == S_START)
            tx_n = 1'b0;
        else if (state_n == S_DATA)
            tx_n = char_n[bit_n];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            dig_idx  <= '0;
            snap     <= '0;
            uart_tx  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            dig_idx  <= dig_n;
            snap     <= snap_n;
            uart_tx  <= tx_n;
            busy     <= busy_n;
            done     <= done_n;
            err      <= err_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_report.sv
// Self-checking bench for uart_tx_report: per-cycle reference model plus a line receiver.
// Build with TX_CRLF_EN defined to exercise the CR/LF trailer.
module tb_uart_tx_report;
    localparam int BT = 4;
    localparam int ND = 7;
`ifdef TX_CRLF_EN
    localparam int NC = ND + 2;
    localparam int EXP_BUSY = 360;
    localparam int EXP_DONE = 361;
`else
    localparam int NC = ND;
    localparam int EXP_BUSY = 280;
    localparam int EXP_DONE = 281;
`endif
    localparam int REPLEN = NC * 10 * BT;

    logic clk = 1'b0;
    logic rst, start;
    logic [4*ND-1:0] bcd;
    logic uart_tx, busy, done, err;

    uart_tx_report #(.BIT_TICKS(BT), .N_DIG(ND)) dut (
        .clk(clk), .rst(rst), .start(start), .bcd(bcd),
        .uart_tx(uart_tx), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    logic rst_q = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference model: a report is a precomputed line waveform indexed by cycles since acceptance.
    logic m_stream [NC*10];
    logic m_errAt  [NC];
    logic m_active = 1'b0;
    logic m_valid  = 1'b0;
    int   m_pos    = 0;
    logic e_tx = 1'b1, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;

    always @(posedge clk) begin : model
        int d;
        logic [7:0] c;
        logic bad;
        if (rst) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
        end else if (m_valid) begin
            if (!e_busy && start) begin
                bad = 1'b0;
                for (int j = 0; j < NC; j++) begin
                    if (j < ND) begin
                        d   = int'((bcd >> (4 * (ND - 1 - j))) & 28'hF);
                        bad = bad | (d > 9);
                        c   = (d > 9) ? 8'h3F : 8'(48 + d);
                    end else begin
                        c = (j == ND) ? 8'h0D : 8'h0A;
                    end
                    m_errAt[j] = bad;
                    for (int b = 0; b < 10; b++) begin
                        if (b == 0)      m_stream[j*10+b] = 1'b0;
                        else if (b == 9) m_stream[j*10+b] = 1'b1;
                        else             m_stream[j*10+b] = c[b-1];
                    end
                end
                m_active = 1'b1;
                m_pos    = 1;
            end else if (m_active) begin
                m_pos++;
            end
            if (m_active && m_pos <= REPLEN) begin
                e_tx   = m_stream[(m_pos-1)/BT];
                e_busy = 1'b1;
                e_done = 1'b0;
                e_err  = m_errAt[(m_pos-1)/(10*BT)];
            end else if (m_active) begin
                e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b1;
                m_active = 1'b0;
            end else begin
                e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("model uart_tx", uart_tx, e_tx);
            checkOutput("model busy", busy, e_busy);
            checkOutput("model done", done, e_done);
            checkOutput("model err", err, e_err);
        end
    end

    // Line receiver sampling mid-bit, plus done/busy counters.
    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] rx_sh = 8'h00;
    logic rx_on = 1'b0;
    int rx_cnt = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    always @(negedge clk) begin
        if (rst_q) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (uart_tx === 1'b0) begin
                rx_on  = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % BT == BT/2 && rx_cnt/BT >= 1 && rx_cnt/BT <= 8)
                rx_sh[rx_cnt/BT-1] = uart_tx;
            if (rx_cnt == 9*BT + BT/2) begin
                rx_q.push_back(rx_sh);
                rx_on = 1'b0;
            end
        end
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    task automatic clearMon();
        rx_q.delete();
        done_cnt = 0;
        busy_cnt = 0;
    endtask

    task automatic applyStimulus(input logic [4*ND-1:0] v, input int hold, output int t0);
        bcd   = v;
        start = 1'b1;
        t0    = cyc;
        repeat (hold) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget, output int t);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (done !== 1'b1) checkOutput({name, " timeout"}, 0, 1);
        t = cyc;
    endtask

    task automatic pushTrailer();
`ifdef TX_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic pushStd();
        exp_q.push_back(8'h37); exp_q.push_back(8'h32); exp_q.push_back(8'h34);
        exp_q.push_back(8'h32); exp_q.push_back(8'h34); exp_q.push_back(8'h34);
        exp_q.push_back(8'h35);
        pushTrailer();
    endtask

    task automatic checkChars(input string name);
        checkOutput({name, " char count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < rx_q.size()) checkOutput({name, " char"}, rx_q[i], exp_q[i]);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0, t1;
        int off;
        logic fb [10];
        logic [4*ND-1:0] v;
        fb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        rst = 1'b1; start = 1'b0; bcd = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset uart_tx", uart_tx, 1);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset err", err, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] test 1: basic report");
        clearMon();
        bcd = 28'h7242445; start = 1'b1; t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 10*BT; k++) begin
            checkOutput("first frame bit", uart_tx, fb[(k-1)/BT]);
            @(negedge clk);
        end
        waitDone("test1 done", REPLEN + 20, t1);
        checkOutput("test1 done latency", t1 - t0, EXP_DONE);
        checkOutput("test1 err", err, 0);
        repeat (4) @(negedge clk);
        checkOutput("test1 busy cycles", busy_cnt, EXP_BUSY);
        exp_q.delete(); pushStd();
        checkChars("test1");

        $display("[TB] test 2: invalid digit");
        clearMon();
        applyStimulus(28'h72A2445, 1, t0);
        waitDone("test2 done", REPLEN + 20, t1);
        checkOutput("test2 err sticky", err, 1);
        repeat (4) @(negedge clk);
        checkOutput("test2 err held", err, 1);
        exp_q.delete();
        exp_q.push_back(8'h37); exp_q.push_back(8'h32); exp_q.push_back(8'h3F);
        exp_q.push_back(8'h32); exp_q.push_back(8'h34); exp_q.push_back(8'h34);
        exp_q.push_back(8'h35);
        pushTrailer();
        checkChars("test2");
        clearMon();
        applyStimulus(28'h7242445, 1, t0);
        checkOutput("test2 err cleared on accept", err, 0);
        waitDone("test2b done", REPLEN + 20, t1);
        repeat (4) @(negedge clk);

        $display("[TB] test 3: start while busy");
        clearMon();
        applyStimulus(28'h7242445, 1, t0);
        repeat (99) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone("test3 done", REPLEN + 20, t1);
        repeat (6) @(negedge clk);
        checkOutput("test3 single done", done_cnt, 1);
        checkOutput("test3 idle after", busy, 0);
        exp_q.delete(); pushStd();
        checkChars("test3");

        $display("[TB] test 4: bcd changes after accept");
        clearMon();
        applyStimulus(28'h7242445, 1, t0);
        bcd = 28'h0000000;
        waitDone("test4 done", REPLEN + 20, t1);
        repeat (4) @(negedge clk);
        exp_q.delete(); pushStd();
        checkChars("test4");

        $display("[TB] test 5: reset mid-frame");
        clearMon();
        applyStimulus(28'h7242445, 1, t0);
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("test5 uart_tx after reset", uart_tx, 1);
        checkOutput("test5 busy after reset", busy, 0);
        repeat (REPLEN) @(negedge clk);
        checkOutput("test5 no done", done_cnt, 0);
        clearMon();
        applyStimulus(28'h7242445, 1, t0);
        waitDone("test5 done", REPLEN + 20, t1);
        repeat (4) @(negedge clk);
        exp_q.delete(); pushStd();
        checkChars("test5");

        $display("[TB] test 6: start held high");
        clearMon();
        bcd = 28'h7242445; start = 1'b1; t0 = cyc;
        @(negedge clk);
        waitDone("test6 first done", REPLEN + 20, t1);
        checkOutput("test6 gap high", uart_tx, 1);
        @(negedge clk);
        checkOutput("test6 restart low", uart_tx, 0);
        waitDone("test6 second done", REPLEN + 20, t1);
        start = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("test6 done pulses", done_cnt, 2);
        checkOutput("test6 busy cycles", busy_cnt, 2 * EXP_BUSY);
        exp_q.delete(); pushStd(); pushStd();
        checkChars("test6");

        $display("[TB] random reports");
        for (int r = 0; r < 8; r++) begin
            v = '0;
            for (int j = 0; j < ND; j++) begin
                v = v << 4;
                if ($urandom_range(0, 3) == 0) v[3:0] = 4'($urandom_range(10, 15));
                else                           v[3:0] = 4'($urandom_range(0, 9));
            end
            applyStimulus(v, $urandom_range(1, 3), t0);
            off = $urandom_range(5, REPLEN - 20);
            repeat (off) @(negedge clk);
            if (r == 5) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                start = 1'b1;
                bcd = 28'($urandom);
                @(negedge clk);
                start = 1'b0;
                waitDone("random done", REPLEN + 20, t1);
            end
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
